// File: rtl/bcd_serial_alu_pkg.sv
// bcd_pkg: shared types and helpers for the digit-serial BCD add/subtract unit.
//   state_t      : controller states (IDLE, CALC, FIX, DONE)
//   OP_ADD/OP_SUB: encodings of the op input
//   BCD_BLANK    : nibble written to every result digit on an invalid input
//   SEG7_TABLE   : active-low 7-segment patterns {a,b,c,d,e,f,g} for 0..9
//   SEG7_BLANK   : all segments off
//   bcd_valid()  : nibble is a legal BCD digit
//   seg7_decode(): digit to segment pattern, blank for non-BCD nibbles
// Optional feature macro: BCD_SEG7_EN (enables the seg output of the top).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  localparam logic [6:0] SEG7_TABLE [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return nibble <= 4'd9;
  endfunction

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    if (bcd_valid(nibble)) return SEG7_TABLE[nibble];
    return SEG7_BLANK;
  endfunction

endpackage

// File: rtl/bcd_serial_alu_if.sv
// bcd_serial_alu_if: operand/result handshake bundle of bcd_serial_alu.
//   in_valid/in_ready  : operand handshake (op, a, b)
//   out_valid/out_ready: result handshake (result, neg, ovf, err[, seg])
//   master modport: producer/consumer side (switch capture + display driver)
//   slave modport : the arithmetic unit
// With BCD_SEG7_EN defined the bundle also carries seg (7 bits per digit).
interface bcd_serial_alu_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  op;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   result;
  logic                  neg;
  logic                  ovf;
  logic                  err;
`ifdef BCD_SEG7_EN
  logic [7*DIGITS-1:0]   seg;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, neg, ovf, err
`ifdef BCD_SEG7_EN
    , input seg
`endif
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, neg, ovf, err
`ifdef BCD_SEG7_EN
    , output seg
`endif
  );

endinterface

// File: rtl/bcd_serial_alu_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder.
//   a, b : BCD digits (0..9)
//   cin  : carry in
//   sum  : BCD sum digit
//   cout : decimal carry out
// A binary sum above 9 is corrected by +6, which also wraps it into 0..9.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] bin_sum;

  assign bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign cout    = bin_sum > 5'd9;
  assign sum     = cout ? 4'(bin_sum + 5'd6) : bin_sum[3:0];

endmodule

// File: rtl/bcd_serial_alu.sv
// bcd_serial_alu: digit-serial packed-BCD add/subtract, one digit per clock,
// least-significant digit first, sign/magnitude result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_serial_alu_if.slave (operand and result handshakes)
// Subtraction adds the nines' complement of b with carry-in 1; a missing final
// carry means a<b, and the stored result is then ten's-complemented in FIX to
// give the magnitude. Results are presented one cycle after DONE is entered.
// Optional feature macro: BCD_SEG7_EN adds the registered seg output.
module bcd_serial_alu
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_alu_if.slave    bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic             op_reg;
  logic [W-1:0]     a_reg, b_reg, result_reg;
  logic             neg_reg, ovf_reg, err_reg;
  logic             in_ready_reg, out_valid_reg;
  logic [W-1:0]     result_next;

  logic [3:0]       a_dig [DIGITS];
  logic [3:0]       b_dig [DIGITS];
  logic [3:0]       r_dig [DIGITS];
  logic [DIGITS-1:0] nib_ok;
  logic             in_ok, accept, busy, enter_done;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cout;

  assign accept = (state_reg == IDLE) && bus.in_valid && in_ready_reg;
  assign busy   = (state_reg == CALC) || (state_reg == FIX);
  assign in_ok  = &nib_ok;

  // Digit views of the registers, input validity, and the next result with
  // the digit under the index replaced by the adder output.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign a_dig[gi]  = a_reg[gi*4 +: 4];
    assign b_dig[gi]  = b_reg[gi*4 +: 4];
    assign r_dig[gi]  = result_reg[gi*4 +: 4];
    assign nib_ok[gi] = bcd_valid(bus.a[gi*4 +: 4]) && bcd_valid(bus.b[gi*4 +: 4]);
    assign result_next[gi*4 +: 4] =
        accept ? (in_ok ? 4'd0 : BCD_BLANK) :
        (busy && (idx_reg == IDX_W'(gi))) ? add_sum : r_dig[gi];
  end

  // One adder serves both phases: a + b (or 9-b) in CALC, (9-d) + carry in FIX.
  always_comb begin
    add_a = a_dig[idx_reg];
    add_b = (op_reg == OP_SUB) ? (4'd9 - b_dig[idx_reg]) : b_dig[idx_reg];
    if (state_reg == FIX) begin
      add_a = 4'd9 - r_dig[idx_reg];
      add_b = 4'd0;
    end
  end

  bcd_digit_add u_digit_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign enter_done = (accept && !in_ok)
                   || ((state_reg == CALC) && (idx_reg == LAST)
                       && !((op_reg == OP_SUB) && !add_cout))
                   || ((state_reg == FIX) && (idx_reg == LAST));

`ifdef BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg_reg, seg_next;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    assign seg_next[gi*7 +: 7] = seg7_decode(result_next[gi*4 +: 4]);
  end
  assign bus.seg = seg_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      op_reg        <= OP_ADD;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      neg_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
`ifdef BCD_SEG7_EN
      seg_reg       <= '1;
`endif
    end else begin
`ifdef BCD_SEG7_EN
      if (enter_done) seg_reg <= seg_next;
`endif
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg        <= bus.a;
            b_reg        <= bus.b;
            op_reg       <= bus.op;
            result_reg   <= result_next;
            neg_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            idx_reg      <= '0;
            carry_reg    <= bus.op;
            in_ready_reg <= 1'b0;
            err_reg      <= !in_ok;
            state_reg    <= in_ok ? CALC : DONE;
          end
        end
        CALC: begin
          result_reg <= result_next;
          carry_reg  <= add_cout;
          if (idx_reg == LAST) begin
            idx_reg <= '0;
            if (op_reg == OP_ADD) begin
              ovf_reg   <= add_cout;
              state_reg <= DONE;
            end else if (add_cout) begin
              state_reg <= DONE;
            end else begin
              // No borrow-free carry: a<b, magnitude needs ten's complement.
              neg_reg   <= 1'b1;
              carry_reg <= 1'b1;
              state_reg <= FIX;
            end
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        FIX: begin
          result_reg <= result_next;
          carry_reg  <= add_cout;
          if (idx_reg == LAST) begin
            idx_reg   <= '0;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            out_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.neg       = neg_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Testbench for bcd_serial_alu (DIGITS=4). An arithmetic model converts the
// BCD operands to integers and derives result/neg/ovf/err/latency; a negedge
// compare process checks the DUT against it every cycle. Optional macro:
// BCD_SEG7_EN (also checks seg).
module tb_bcd_serial_alu;
  localparam int D = 4;
  localparam int W = 4 * D;

  typedef struct {
    logic [W-1:0] result;
    logic         neg;
    logic         ovf;
    logic         err;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_alu_if #(.DIGITS(D)) bus ();
  bcd_serial_alu #(.DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  exp_t cur_exp;
  bit   exp_active = 1'b0;
  bit   skip_cmp   = 1'b0;
  int   acc_id     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input longint x);
    logic [W-1:0] r;
    longint v;
    r = '0;
    v = x;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv);
    exp_t   e;
    longint ai, bi, p;
    bit     bad;
    ai = 0; bi = 0; p = 1; bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
      ai += longint'(av[4*i +: 4]) * p;
      bi += longint'(bv[4*i +: 4]) * p;
      p  *= 10;
    end
    e.result = '0; e.neg = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = D + 1;
    if (bad) begin
      e.err = 1'b1; e.result = '1; e.lat = 1;
    end else if (!opv) begin
      e.ovf = (ai + bi) >= p;
      e.result = to_bcd((ai + bi) % p);
    end else if (ai >= bi) begin
      e.result = to_bcd(ai - bi);
    end else begin
      e.result = to_bcd(bi - ai);
      e.neg = 1'b1;
      e.lat = 2 * D + 1;
    end
    return e;
  endfunction

`ifdef BCD_SEG7_EN
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;  4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;  4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;  4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;  4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;  4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*D-1:0] segs_of(input logic [W-1:0] r);
    logic [7*D-1:0] s;
    for (int i = 0; i < D; i++) s[7*i +: 7] = seg_of(r[4*i +: 4]);
    return s;
  endfunction
`endif

  // Compare process: every negedge, outputs against the model.
  int neg_cnt = 0;
  int acc_seen = 0;
  always @(negedge clk) begin
    if (!skip_cmp) begin
      if (exp_active) begin
        if (acc_seen != acc_id) begin
          acc_seen = acc_id;
          neg_cnt = 0;
        end
        neg_cnt++;
        chk("in_ready_busy", bus.in_ready, 0);
        if (neg_cnt - 1 < cur_exp.lat) begin
          chk("out_valid_early", bus.out_valid, 0);
        end else begin
          chk("out_valid", bus.out_valid, 1);
          chk("result", bus.result, cur_exp.result);
          chk("neg", bus.neg, cur_exp.neg);
          chk("ovf", bus.ovf, cur_exp.ovf);
          chk("err", bus.err, cur_exp.err);
`ifdef BCD_SEG7_EN
          chk("seg", bus.seg, segs_of(cur_exp.result));
`endif
        end
      end else begin
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_result", bus.result, cur_exp.result);
        chk("idle_flags", {bus.neg, bus.ovf, bus.err}, {cur_exp.neg, cur_exp.ovf, cur_exp.err});
      end
    end
  end

  task automatic pin(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv,
                     input logic [W-1:0] r, input logic n, input logic o, input logic e, input int lat);
    exp_t m;
    m = model(av, bv, opv);
    chk("model_result", m.result, r);
    chk("model_flags", {m.neg, m.ovf, m.err}, {n, o, e});
    chk("model_lat", m.lat, lat);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv,
                        input int hold, input bit junk);
    exp_t e;
    int   n;
    logic [W-1:0] r_seen;
    logic [2:0]   f_seen;
    e = model(av, bv, opv);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.op = opv; bus.in_valid = 1'b1;
    @(posedge clk);
    cur_exp = e;
    acc_id++;
    exp_active = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 4 * D + 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      chk("out_valid_timeout", bus.out_valid, 1);
    end
    r_seen = bus.result;
    f_seen = {bus.neg, bus.ovf, bus.err};
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.op = ~opv;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    exp_active = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("txn %s a=%h b=%h result=%h neg=%0d ovf=%0d err=%0d",
             opv ? "sub" : "add", av, bv, r_seen, f_seen[2], f_seen[1], f_seen[0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_exp = '{result: '0, neg: 1'b0, ovf: 1'b0, err: 1'b0, lat: 0};
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 1'b0;
    bus.a = '0; bus.b = '0;

    // Hand-computed pins of the model itself.
    pin(16'h1234, 16'h5678, 1'b0, 16'h6912, 0, 0, 0, 5);
    pin(16'h9999, 16'h0001, 1'b0, 16'h0000, 0, 1, 0, 5);
    pin(16'h0500, 16'h0123, 1'b1, 16'h0377, 0, 0, 0, 5);
    pin(16'h0123, 16'h0500, 1'b1, 16'h0377, 1, 0, 0, 9);
    pin(16'h4321, 16'h4321, 1'b1, 16'h0000, 0, 0, 0, 5);
    pin(16'h12A4, 16'h0001, 1'b0, 16'hFFFF, 0, 0, 1, 1);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(16'h1234, 16'h5678, 1'b0, 0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0500, 16'h0123, 1'b1, 0, 1'b0);
    run_op(16'h0123, 16'h0500, 1'b1, 0, 1'b0);
    run_op(16'h4321, 16'h4321, 1'b1, 0, 1'b0);
    run_op(16'h0000, 16'h9999, 1'b1, 2, 1'b0);
    run_op(16'h12A4, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0002, 16'h0003, 1'b0, 0, 1'b0);
    run_op(16'h5555, 16'h4445, 1'b0, 0, 1'b0);
    // Backpressure: result held for 10 cycles while new requests are offered.
    run_op(16'h0042, 16'h0019, 1'b1, 10, 1'b1);

    // Asynchronous reset between clock edges in the middle of CALC.
    skip_cmp = 1'b1;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.op = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_flags", {bus.neg, bus.ovf, bus.err}, 3'b000);
`ifdef BCD_SEG7_EN
    chk("rst_seg", bus.seg, {7*D{1'b1}});
`endif
    cur_exp = '{result: '0, neg: 1'b0, ovf: 1'b0, err: 1'b0, lat: 0};
    skip_cmp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0007, 16'h0003, 1'b0, 0, 1'b0);
    chk("lit_0007_0003", cur_exp.result, 16'h0010);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_alu.md
Name: bcd_serial_alu

Overview:
Parametrised digit-serial BCD add/subtract unit; successor to the fixed 2-digit combinational BCD adder on the board datapath.
- Processes DIGITS packed BCD digits, one digit per clock, least-significant digit first.
- Supports add and subtract with a sign/magnitude result, an overflow flag and invalid-digit detection.
- Sits between the switch/operand capture logic and the display driver, with valid/ready handshakes on both sides.

Parameters:
DIGITS, 4, number of BCD digits per operand and result (1..8).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands and op are valid.
in_ready  output  1  unit can accept a new operation; high only in IDLE.
op  input  1  0 = add (a+b), 1 = subtract (a-b).
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD.
out_valid  output  1  result fields valid; held until accepted.
out_ready  input  1  consumer accepts the result.
result  output  4*DIGITS  magnitude of the result, packed BCD.
neg  output  1  result is negative (subtract only, a<b).
ovf  output  1  add carry out of the top digit; result holds the low DIGITS digits.
err  output  1  an input nibble was >9; result is all 4'hF.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; result=0; neg=0; ovf=0; err=0; internal digit index and carry = 0. Reset mid-operation abandons the operation with no output.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on in_valid&&in_ready, register a, b and op, and clear result, neg, ovf and err.
  - If any nibble of a or b is >9: set err, set result to all F, go to DONE.
  - Otherwise go to CALC with index=0 and carry=op.
- CALC: each cycle computes digit[index] = a_d + (op ? 9-b_d : b_d) + carry using bcd_digit_add, which applies the +6 correction when the binary sum is >9, with carry out to the next digit. Index increments; after index DIGITS-1 the final carry is evaluated:
  - add: ovf = carry, go to DONE.
  - sub, carry=1: a>=b, result is final, neg=0, go to DONE.
  - sub, carry=0: a<b, neg=1, go to FIX.
- FIX: ten's complement of result, one digit per cycle. Each digit is replaced by (9-d)+c, with c=1 at digit 0 and propagated as a BCD carry. After DIGITS cycles, go to DONE.
- DONE: out_valid=1. result, neg, ovf and err stay stable while out_valid && !out_ready. On out_valid&&out_ready, go to IDLE and drop out_valid the next cycle. Fields keep their values until the next accept.
- Latency: if the handshake completes on edge k, out_valid rises after edge k+DIGITS+1 for add or non-negative sub, after edge k+2*DIGITS+1 for negative sub, and after edge k+1 for err.
- No pipelining; in_ready=0 from the accept edge until the return to IDLE.
- Equal operands (a-b=0): result=0, neg=0. Never a negative zero.
- ovf is never set for subtract. neg is never set for add.
- Inputs are ignored outside IDLE.

Optional Feature:
BCD_SEG7_EN.
- Defined: adds output port seg, width 7*DIGITS, registered, one active-low 7-segment field per result digit. The MSB of each field is segment a and the LSB is segment g, so 0 -> 7'b0000001 and 1 -> 7'b1001111. Non-BCD digits -> 7'b1111111 (blank). seg updates on the DONE entry edge, and resets to all ones.
- Undefined: port and decode logic are absent; the board-level decoder is used.

Decomposition:
- Package bcd_pkg: state enum (IDLE, CALC, FIX, DONE), op encodings OP_ADD=0 and OP_SUB=1, BCD_BLANK=4'hF, the 10-entry 7-segment table constant plus blank, and a function bcd_valid(nibble).
- One sub-module, bcd_digit_add: combinational single-digit BCD adder. Inputs: 4-bit a, 4-bit b, cin. Outputs: 4-bit sum, cout. Shared by CALC and FIX.

Test Plan:
- Add, DIGITS=4, a=1234, b=5678 -> result=6912, ovf=0, neg=0, out_valid 5 cycles after accept.
- Add, a=9999, b=0001 -> result=0000, ovf=1.
- Subtract, a=0500, b=0123 -> result=0377, neg=0 after 5 cycles. a=0123, b=0500 -> result=0377, neg=1 after 9 cycles. a=b=4321 -> 0000, neg=0.
- Invalid digit, a=16'h12A4 -> err=1, result=16'hFFFF, out_valid 1 cycle after accept. Next valid op clears err.
- Backpressure: out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle.
- Async reset asserted mid-CALC, between clock edges -> all outputs at reset values immediately. After release, 0007+0003 -> 0010.
